// File: rtl/ob_cmd_ingress.sv
// rtl/ob_cmd_ingress.sv - multi-channel order-book command ingress with per-channel queues and arbitration
package ob_pkg;
  typedef enum logic [1:0] {OP_ADD, OP_CANCEL, OP_MODIFY, OP_QUERY} op_t;
  typedef struct packed {
    op_t         op;
    logic        side;
    logic [12:0] oid;
    logic [15:0] px;
  } cmd_t;
endpackage

module ob_cmd_ingress #(
  parameter int N        = 4,
  parameter int DEPTH    = 4,
  parameter int W        = $bits(ob_pkg::cmd_t),
  parameter int ARB_MODE = 0,
  parameter int CHAN_W   = (N > 1) ? $clog2(N) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      cmd_vld_r,
  input  logic [N*W-1:0]    cmd_r,
  output logic [N-1:0]      cmd_full_r,
  input  logic [N-1:0]      flush,
  output logic              out_vld,
  output logic [W-1:0]      out_data,
  output logic [CHAN_W-1:0] out_chan,
  input  logic              out_pop,
  output logic [N-1:0]      ovf_err_r
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]      r_mem    [N][DEPTH];
  logic [PTR_W-1:0]  r_rd_ptr [N];
  logic [PTR_W-1:0]  r_wr_ptr [N];
  logic [CNT_W-1:0]  r_occ    [N];
  logic [CNT_W-1:0]  w_occ_nxt[N];
  logic [CHAN_W-1:0] rr_ptr_r;
  logic [CHAN_W-1:0] w_sel;
  logic [N-1:0]      w_elig;
  logic [N-1:0]      w_push;
  logic [N-1:0]      w_pop_ch;
  logic [N-1:0]      w_ovf;
  logic              w_found;
  logic              w_pop;

  function automatic logic [PTR_W-1:0] f_ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    w_elig = '0;
    for (int i = 0; i < N; i++) begin
      w_elig[i] = (r_occ[i] != '0);
    end
  end

  // Arbitration sees only registered state, so out_* never depend on inputs.
  always_comb begin : p_arb
    int                j;
    logic [CHAN_W-1:0] idx;
    j       = 0;
    idx     = '0;
    w_sel   = '0;
    w_found = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = (ARB_MODE == 0) ? int'(rr_ptr_r) + k : k;
      if (j >= N) begin
        j = j - N;
      end
      idx = CHAN_W'(j);
      if (!w_found && w_elig[idx]) begin
        w_found = 1'b1;
        w_sel   = idx;
      end
    end
  end

  assign out_vld  = w_found;
  assign out_chan = w_sel;
  assign out_data = r_mem[w_sel][r_rd_ptr[w_sel]];
  assign w_pop    = out_pop & w_found;

  // Full check uses pre-edge occupancy; flush discards a same-cycle push silently.
  always_comb begin
    w_pop_ch = '0;
    w_push   = '0;
    w_ovf    = '0;
    for (int i = 0; i < N; i++) begin
      w_pop_ch[i]  = w_pop && (w_sel == CHAN_W'(i));
      w_push[i]    = cmd_vld_r[i] && !flush[i] && (r_occ[i] != CNT_W'(DEPTH));
      w_ovf[i]     = cmd_vld_r[i] && !flush[i] && (r_occ[i] == CNT_W'(DEPTH));
      w_occ_nxt[i] = r_occ[i];
      if (flush[i]) begin
        w_occ_nxt[i] = '0;
      end else if (w_push[i] && !w_pop_ch[i]) begin
        w_occ_nxt[i] = r_occ[i] + CNT_W'(1);
      end else if (!w_push[i] && w_pop_ch[i]) begin
        w_occ_nxt[i] = r_occ[i] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        r_rd_ptr[i] <= '0;
        r_wr_ptr[i] <= '0;
        r_occ[i]    <= '0;
      end
      cmd_full_r <= '0;
      ovf_err_r  <= '0;
      rr_ptr_r   <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        r_occ[i]      <= w_occ_nxt[i];
        cmd_full_r[i] <= (w_occ_nxt[i] == CNT_W'(DEPTH));
        ovf_err_r[i]  <= ovf_err_r[i] | w_ovf[i];
        if (flush[i]) begin
          r_rd_ptr[i] <= '0;
          r_wr_ptr[i] <= '0;
        end else begin
          if (w_push[i]) begin
            r_wr_ptr[i] <= f_ptr_inc(r_wr_ptr[i]);
          end
          if (w_pop_ch[i]) begin
            r_rd_ptr[i] <= f_ptr_inc(r_rd_ptr[i]);
          end
        end
      end
      if (w_pop) begin
        rr_ptr_r <= (w_sel == CHAN_W'(N - 1)) ? '0 : w_sel + CHAN_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (w_push[i]) begin
        r_mem[i][r_wr_ptr[i]] <= cmd_r[i*W +: W];
      end
    end
  end

endmodule

// File: tb/tb_ob_cmd_ingress.sv
// tb/tb_ob_cmd_ingress.sv - directed bench for ob_cmd_ingress in round-robin, fixed-priority and DEPTH=3 builds
module tb_ob_cmd_ingress;
  localparam int W = $bits(ob_pkg::cmd_t);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [3:0]   a_vld, a_flush, a_full, a_ovf;
  logic [4*W-1:0] a_cmd;
  logic         a_pop, a_ovld;
  logic [W-1:0] a_data;
  logic [1:0]   a_chan;

  logic [3:0]   b_vld, b_flush, b_full, b_ovf;
  logic [4*W-1:0] b_cmd;
  logic         b_pop, b_ovld;
  logic [W-1:0] b_data;
  logic [1:0]   b_chan;

  logic [3:0]   c_vld, c_flush, c_full, c_ovf;
  logic [4*W-1:0] c_cmd;
  logic         c_pop, c_ovld;
  logic [W-1:0] c_data;
  logic [1:0]   c_chan;

  int checks = 0;
  int errors = 0;

  ob_cmd_ingress #(.N(4), .DEPTH(4), .ARB_MODE(0)) u_rr (
    .clk(clk), .rst(rst), .cmd_vld_r(a_vld), .cmd_r(a_cmd), .cmd_full_r(a_full),
    .flush(a_flush), .out_vld(a_ovld), .out_data(a_data), .out_chan(a_chan),
    .out_pop(a_pop), .ovf_err_r(a_ovf)
  );

  ob_cmd_ingress #(.N(4), .DEPTH(4), .ARB_MODE(1)) u_fp (
    .clk(clk), .rst(rst), .cmd_vld_r(b_vld), .cmd_r(b_cmd), .cmd_full_r(b_full),
    .flush(b_flush), .out_vld(b_ovld), .out_data(b_data), .out_chan(b_chan),
    .out_pop(b_pop), .ovf_err_r(b_ovf)
  );

  ob_cmd_ingress #(.N(4), .DEPTH(3), .ARB_MODE(0)) u_d3 (
    .clk(clk), .rst(rst), .cmd_vld_r(c_vld), .cmd_r(c_cmd), .cmd_full_r(c_full),
    .flush(c_flush), .out_vld(c_ovld), .out_data(c_data), .out_chan(c_chan),
    .out_pop(c_pop), .ovf_err_r(c_ovf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    a_vld = '0; a_cmd = '0; a_flush = '0; a_pop = 1'b0;
    b_vld = '0; b_cmd = '0; b_flush = '0; b_pop = 1'b0;
    c_vld = '0; c_cmd = '0; c_flush = '0; c_pop = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_a_vld", 64'(a_ovld), 64'd0);
    chk("rst_a_full", 64'(a_full), 64'd0);
    chk("rst_a_ovf", 64'(a_ovf), 64'd0);
    chk("rst_b_vld", 64'(b_ovld), 64'd0);
    chk("rst_c_full", 64'(c_full), 64'd0);

    // single push on channel 2, no same-cycle bypass
    a_vld = 4'b0100;
    a_cmd[2*W +: W] = W'(32'hA0A0_0002);
    chk("no_bypass", 64'(a_ovld), 64'd0);
    tick();
    a_vld = '0;
    chk("push_vld", 64'(a_ovld), 64'd1);
    chk("push_chan", 64'(a_chan), 64'd2);
    chk("push_data", 64'(a_data), 64'hA0A0_0002);
    a_pop = 1'b1;
    tick();
    a_pop = 1'b0;
    chk("push_drained", 64'(a_ovld), 64'd0);

    // reset mid-operation discards queued data and rr pointer
    a_vld = 4'b0001;
    a_cmd[0 +: W] = W'(32'hDEAD_0000);
    tick();
    a_vld = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_reset_vld", 64'(a_ovld), 64'd0);

    // round-robin over four preloaded channels
    for (int s = 0; s < 2; s++) begin
      a_vld = 4'hF;
      for (int c = 0; c < 4; c++) a_cmd[c*W +: W] = W'(32'h1000_0000 + c*16 + s);
      tick();
    end
    a_vld = '0;
    for (int k = 0; k < 8; k++) begin
      chk("rr_vld", 64'(a_ovld), 64'd1);
      chk("rr_chan", 64'(a_chan), 64'(k % 4));
      chk("rr_data", 64'(a_data), 64'(32'h1000_0000 + (k % 4)*16 + k/4));
      a_pop = 1'b1;
      tick();
    end
    a_pop = 1'b0;
    chk("rr_empty", 64'(a_ovld), 64'd0);

    // fill channel 0 to DEPTH, overflow, then drain in order
    for (int s = 0; s < 4; s++) begin
      a_vld = 4'b0001;
      a_cmd[0 +: W] = W'(32'h2000_0000 + s);
      tick();
      if (s == 2) chk("full_at_3", 64'(a_full), 64'd0);
    end
    chk("full_at_4", 64'(a_full), 64'h1);
    chk("no_ovf_yet", 64'(a_ovf), 64'd0);
    a_cmd[0 +: W] = W'(32'h2000_00FF);
    tick();
    a_vld = '0;
    chk("ovf_set", 64'(a_ovf), 64'h1);
    chk("full_held", 64'(a_full), 64'h1);
    for (int s = 0; s < 4; s++) begin
      chk("ovf_drain_data", 64'(a_data), 64'(32'h2000_0000 + s));
      a_pop = 1'b1;
      tick();
      if (s == 0) chk("full_clear", 64'(a_full), 64'd0);
    end
    a_pop = 1'b0;
    chk("ovf_sticky", 64'(a_ovf), 64'h1);
    chk("ovf_empty", 64'(a_ovld), 64'd0);

    // push and pop together at full: push dropped
    for (int s = 0; s < 4; s++) begin
      a_vld = 4'b1000;
      a_cmd[3*W +: W] = W'(32'h3000_0000 + s);
      tick();
    end
    a_cmd[3*W +: W] = W'(32'h3000_00EE);
    a_pop = 1'b1;
    chk("pp_chan", 64'(a_chan), 64'd3);
    tick();
    a_vld = '0;
    a_pop = 1'b0;
    chk("pp_full", 64'(a_full), 64'd0);
    chk("pp_ovf", 64'(a_ovf), 64'h9);
    for (int s = 1; s < 4; s++) begin
      chk("pp_data", 64'(a_data), 64'(32'h3000_0000 + s));
      a_pop = 1'b1;
      tick();
    end
    a_pop = 1'b0;
    chk("pp_empty", 64'(a_ovld), 64'd0);

    // flush with simultaneous push and pop on channel 1
    for (int s = 0; s < 3; s++) begin
      a_vld = 4'b0010;
      a_cmd[1*W +: W] = W'(32'h4000_0000 + s);
      tick();
    end
    a_flush = 4'b0010;
    a_cmd[1*W +: W] = W'(32'h4000_00AA);
    a_pop = 1'b1;
    chk("fl_chan", 64'(a_chan), 64'd1);
    tick();
    a_flush = '0;
    a_vld = '0;
    a_pop = 1'b0;
    chk("fl_vld", 64'(a_ovld), 64'd0);
    chk("fl_ovf", 64'(a_ovf), 64'h9);
    chk("fl_full", 64'(a_full), 64'd0);
    a_vld = 4'b0010;
    a_cmd[1*W +: W] = W'(32'h4000_00BB);
    tick();
    a_vld = '0;
    chk("fl_repush_data", 64'(a_data), 64'h4000_00BB);
    a_pop = 1'b1;
    tick();
    a_pop = 1'b0;
    chk("fl_repush_empty", 64'(a_ovld), 64'd0);

    // fixed priority: channel 1 drains before channel 3
    for (int s = 0; s < 3; s++) begin
      b_vld = 4'b1010;
      b_cmd[1*W +: W] = W'(32'h5000_0010 + s);
      b_cmd[3*W +: W] = W'(32'h5000_0030 + s);
      tick();
    end
    b_vld = '0;
    for (int k = 0; k < 6; k++) begin
      chk("fp_chan", 64'(b_chan), (k < 3) ? 64'd1 : 64'd3);
      chk("fp_data", 64'(b_data), (k < 3) ? 64'(32'h5000_0010 + k) : 64'(32'h5000_0030 + k - 3));
      b_pop = 1'b1;
      tick();
    end
    b_pop = 1'b0;
    chk("fp_empty", 64'(b_ovld), 64'd0);

    // DEPTH=3: full at 3, then wrap-around with interleaved push/pop
    for (int s = 0; s < 3; s++) begin
      c_vld = 4'b0001;
      c_cmd[0 +: W] = W'(32'h6000_0000 + s);
      tick();
      if (s == 1) chk("d3_full_at_2", 64'(c_full), 64'd0);
    end
    c_vld = '0;
    chk("d3_full_at_3", 64'(c_full), 64'h1);
    for (int s = 0; s < 3; s++) begin
      chk("d3_drain", 64'(c_data), 64'(32'h6000_0000 + s));
      c_pop = 1'b1;
      tick();
    end
    c_pop = 1'b0;
    c_vld = 4'b0001;
    c_cmd[0 +: W] = W'(32'h7000_0000);
    tick();
    for (int k = 1; k < 10; k++) begin
      c_cmd[0 +: W] = W'(32'h7000_0000 + k);
      c_pop = 1'b1;
      chk("wrap_data", 64'(c_data), 64'(32'h7000_0000 + k - 1));
      tick();
      chk("wrap_full", 64'(c_full), 64'd0);
    end
    c_vld = '0;
    chk("wrap_last", 64'(c_data), 64'h7000_0009);
    tick();
    c_pop = 1'b0;
    chk("wrap_empty", 64'(c_ovld), 64'd0);
    chk("wrap_ovf", 64'(c_ovf), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
